pwm_button_ctrl: RTL and testbench

- Upstream front end for the PWM duty-cycle generator.
- Converts two raw, asynchronous, bouncy pushbuttons (increment and decrement) into clean single-cycle duty_inc/duty_dec pulses on the PWM clock.
- Stages: per-button 2-FF synchronizer, debounce filter, press-edge pulse generator, optional hold-to-auto-repeat, and inc/dec conflict suppression.
- Outputs connect directly to the PWM generator's duty_inc/duty_dec inputs.

---
 rtl/pwm_button_ctrl.sv | 139 +++++++++++++
 tb/tb_pwm_button_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_button_ctrl.sv
// rtl/pwm_button_ctrl.sv - debounced inc/dec pushbuttons to single-cycle PWM duty requests
module pwm_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 32,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic duty_inc,
  output logic duty_dec,
  output logic btn_inc_db,
  output logic btn_dec_db
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  // Illegal counter sizing or timing values stop elaboration.
  if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) > CNT_MAX ||
      REPEAT_DELAY < 1 || longint'(REPEAT_DELAY) > CNT_MAX ||
      REPEAT_PERIOD < 2 || longint'(REPEAT_PERIOD) > CNT_MAX) begin : g_bad_cfg
    $error("pwm_button_ctrl: illegal DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD for CNT_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HOLD, S_REPEAT} state_t;

  // Both debounced levels high now, and after the coming edge.
  logic both;
  logic both_nxt;

  // Index 0 is the increment button, index 1 the decrement button.
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic             raw;
    logic             sync_1;
    logic             sync_2;
    logic             db;
    logic             db_nxt;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] rpt_cnt;
    logic             pulse;
    state_t           state;

    assign raw = (i == 0) ? btn_inc_raw : btn_dec_raw;

    // Debounced level after the coming edge; flips only after a full stable run.
    assign db_nxt = (sync_2 != db && db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) ? sync_2 : db;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_1 <= 1'b0;
        sync_2 <= 1'b0;
      end else begin
        sync_1 <= raw;
        sync_2 <= sync_1;
      end
    end

    // Debounce: count consecutive cycles of disagreement, flip the level at the limit.
    always_ff @(posedge clk) begin
      if (rst) begin
        db     <= 1'b0;
        db_cnt <= '0;
      end else begin
        db <= db_nxt;
        if (sync_2 == db || db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    // Press / hold / auto-repeat FSM; a pulse is dropped if both buttons will be held.
    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= S_IDLE;
        rpt_cnt <= '0;
        pulse   <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (!db) begin
          state   <= S_IDLE;
          rpt_cnt <= '0;
        end else if (both) begin
          // Conflict: park in HOLD so the survivor restarts the delay after release.
          state   <= S_HOLD;
          rpt_cnt <= '0;
        end else begin
          case (state)
            S_IDLE: begin
              state <= S_PRESS;
              pulse <= ~both_nxt;
            end
            S_PRESS: begin
              state   <= S_HOLD;
              rpt_cnt <= '0;
            end
            S_HOLD: begin
              if (REPEAT_EN != 0) begin
                if (rpt_cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                  state   <= S_REPEAT;
                  rpt_cnt <= '0;
                  pulse   <= ~both_nxt;
                end else begin
                  rpt_cnt <= rpt_cnt + 1'b1;
                end
              end
            end
            S_REPEAT: begin
              if (rpt_cnt == CNT_W'(REPEAT_PERIOD - 1)) begin
                rpt_cnt <= '0;
                pulse   <= ~both_nxt;
              end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
              end
            end
            default: begin
              state   <= S_IDLE;
              rpt_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

  assign both     = g_btn[0].db & g_btn[1].db;
  assign both_nxt = g_btn[0].db_nxt & g_btn[1].db_nxt;

  assign duty_inc   = g_btn[0].pulse;
  assign duty_dec   = g_btn[1].pulse;
  assign btn_inc_db = g_btn[0].db;
  assign btn_dec_db = g_btn[1].db;

endmodule

// File: tb/tb_pwm_button_ctrl.sv
// tb/tb_pwm_button_ctrl.sv - bench for pwm_button_ctrl
module tb_pwm_button_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inc_raw = 1'b0;
  logic dec_raw = 1'b0;
  logic inc2_raw = 1'b0;
  logic dec2_raw = 1'b0;
  logic duty_inc, duty_dec, inc_db, dec_db;
  logic n_inc, n_dec, n_inc_db, n_dec_db;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int overlap = 0;
  int inc_q[$];
  int dec_q[$];
  int n_q[$];

  typedef struct {
    logic rst, inc, dec;
    logic e_inc, e_dec, e_idb, e_ddb;
  } vec_t;
  vec_t vecs[$];

  pwm_button_ctrl #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(16), .REPEAT_PERIOD(8), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst(rst), .btn_inc_raw(inc_raw), .btn_dec_raw(dec_raw),
    .duty_inc(duty_inc), .duty_dec(duty_dec), .btn_inc_db(inc_db), .btn_dec_db(dec_db)
  );

  pwm_button_ctrl #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(16), .REPEAT_PERIOD(8), .CNT_W(8)
  ) u_norpt (
    .clk(clk), .rst(rst), .btn_inc_raw(inc2_raw), .btn_dec_raw(dec2_raw),
    .duty_inc(n_inc), .duty_dec(n_dec), .btn_inc_db(n_inc_db), .btn_dec_db(n_dec_db)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (duty_inc === 1'b1) inc_q.push_back(cyc);
    if (duty_dec === 1'b1) dec_q.push_back(cyc);
    if (n_inc === 1'b1) n_q.push_back(cyc);
    if (duty_inc === 1'b1 && duty_dec === 1'b1) overlap++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input int q[$], input int exp[$]);
    chk({name, "_count"}, q.size(), exp.size());
    for (int j = 0; j < exp.size(); j++) begin
      chk($sformatf("%s_%0d", name, j), (j < q.size()) ? q[j] : -1, exp[j]);
    end
  endtask

  task automatic add(input logic r, input logic a, input logic b,
                     input logic ei, input logic ed, input logic eib, input logic edb);
    vec_t v;
    v.rst = r; v.inc = a; v.dec = b;
    v.e_inc = ei; v.e_dec = ed; v.e_idb = eib; v.e_ddb = edb;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; inc_raw = 1'b0; dec_raw = 1'b0; inc2_raw = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    inc_q.delete(); dec_q.delete(); n_q.delete();
  endtask

  initial begin
    int k;
    int exp_q[$];

    // Clean inc press, 3-cycle dec glitch, then bouncy dec press.
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 6; i++) add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 1, 0);
    for (int i = 9; i <= 11; i++) add(0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    for (int i = 13; i <= 17; i++) add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    for (int i = 22; i <= 26; i++) add(0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1);

    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; inc_raw = vecs[i].inc; dec_raw = vecs[i].dec;
      step();
      chk($sformatf("vec%0d", i), int'({duty_inc, duty_dec, inc_db, dec_db}),
          int'({vecs[i].e_inc, vecs[i].e_dec, vecs[i].e_idb, vecs[i].e_ddb}));
    end

    // Auto-repeat: press pulse at k+6, then +17, then every 8.
    do_reset();
    k = cyc + 1;
    inc_raw = 1'b1;
    repeat (56) step();
    inc_raw = 1'b0;
    repeat (30) step();
    exp_q = '{k + 6, k + 23, k + 31, k + 39, k + 47, k + 55};
    chk_q("repeat_inc", inc_q, exp_q);
    chk("repeat_dec_count", dec_q.size(), 0);

    // Conflict: dec pressed 5 cycles after inc; repeats resume 16 after dec_db falls.
    do_reset();
    k = cyc + 1;
    inc_raw = 1'b1;
    repeat (5) step();
    dec_raw = 1'b1;
    repeat (20) step();
    chk("conflict_both_db", int'({inc_db, dec_db}), 3);
    repeat (20) step();
    dec_raw = 1'b0;
    repeat (25) step();
    inc_raw = 1'b0;
    repeat (20) step();
    exp_q = '{k + 6, k + 66, k + 74};
    chk_q("conflict_inc", inc_q, exp_q);
    chk("conflict_dec_count", dec_q.size(), 0);

    // Reset in the repeat phase with the button held.
    do_reset();
    k = cyc + 1;
    inc_raw = 1'b1;
    repeat (36) step();
    rst = 1'b1;
    step();
    chk("rst_cycle1_outs", int'({duty_inc, duty_dec, inc_db, dec_db}), 0);
    step();
    chk("rst_cycle2_outs", int'({duty_inc, duty_dec, inc_db, dec_db}), 0);
    rst = 1'b0;
    step();
    chk("rst_after_outs", int'({duty_inc, duty_dec, inc_db, dec_db}), 0);
    repeat (10) step();
    inc_raw = 1'b0;
    repeat (12) step();
    exp_q = '{k + 6, k + 23, k + 31, k + 44};
    chk_q("rst_inc", inc_q, exp_q);

    // Repeat disabled: one pulse for a long hold.
    do_reset();
    k = cyc + 1;
    inc2_raw = 1'b1;
    repeat (100) step();
    inc2_raw = 1'b0;
    repeat (10) step();
    exp_q = '{k + 6};
    chk_q("norepeat_inc", n_q, exp_q);
    chk("norepeat_dec", int'(n_dec), 0);

    chk("no_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
